// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two 2-entry buffers, round-robin onto one register-file write port.
// Ports: alu_*/ld_* valid/ready requesters, registered WriteAddress/WriteData/ReadWriteEn, pending_mask, idle.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  output logic [ADDR_W-1:0]    WriteAddress,
  output logic [DATA_W-1:0]    WriteData,
  output logic                 ReadWriteEn,
  output logic [2**ADDR_W-1:0] pending_mask,
  output logic                 idle
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t       mem [2][2];
  ent_t       inEnt [2];
  ent_t       head;
  logic [1:0] vld [2];
  logic [1:0] rdPtr;
  logic [1:0] wrPtr;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] full;
  logic [1:0] nonEmpty;
  logic       lastGrant;
  logic       gnt;
  logic       anyGnt;

  always_comb begin
    inEnt[0] = '{addr: alu_addr, data: alu_data};
    inEnt[1] = '{addr: ld_addr, data: ld_data};
    for (int p = 0; p < 2; p++) begin
      full[p]     = &vld[p];
      nonEmpty[p] = |vld[p];
    end
    alu_ready = rst_n & ~full[0];
    ld_ready  = rst_n & ~full[1];
    // r0 writes complete the handshake but are dropped here
    push[0] = alu_valid & alu_ready & (alu_addr != '0);
    push[1] = ld_valid & ld_ready & (ld_addr != '0);
    anyGnt = |nonEmpty;
    gnt = 1'b0;
    unique case (nonEmpty)
      2'b11:   gnt = ~lastGrant;
      2'b10:   gnt = 1'b1;
      default: gnt = 1'b0;
    endcase
    pop = '0;
    if (anyGnt) pop[gnt] = 1'b1;
    head = mem[gnt][rdPtr[gnt]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld[0]       <= '0;
      vld[1]       <= '0;
      rdPtr        <= '0;
      wrPtr        <= '0;
      lastGrant    <= 1'b1;
      ReadWriteEn  <= 1'b0;
      WriteAddress <= '0;
      WriteData    <= '0;
    end else begin
      // push and pop never hit the same slot: a full
      // buffer cannot push, an empty one cannot pop
      for (int p = 0; p < 2; p++) begin
        if (push[p]) begin
          vld[p][wrPtr[p]] <= 1'b1;
          wrPtr[p]         <= ~wrPtr[p];
        end
        if (pop[p]) begin
          vld[p][rdPtr[p]] <= 1'b0;
          rdPtr[p]         <= ~rdPtr[p];
        end
      end
      ReadWriteEn <= anyGnt;
      if (anyGnt) begin
        lastGrant    <= gnt;
        WriteAddress <= head.addr;
        WriteData    <= head.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem[p][wrPtr[p]] <= inEnt[p];
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 2; s++) begin
        if (vld[p][s]) pending_mask[mem[p][s].addr] = 1'b1;
      end
    end
    if (ReadWriteEn) pending_mask[WriteAddress] = 1'b1;
  end

  assign idle = ~(|nonEmpty) & ~ReadWriteEn;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the single register-file write port between two write-back requesters: ALU result (port 0) and load result (port 1).
- Each requester has a 2-entry buffer with valid/ready handshake; round-robin arbitration drains the buffers at one write per cycle.
- Registered outputs drive the register file's WriteAddress/WriteData/ReadWriteEn directly.
- A pending-write mask is exported for the decode stage's hazard check.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (mask width = 2**ADDR_W)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  port 0 write request
- alu_ready  out  1  port 0 buffer can accept
- alu_addr  in  ADDR_W  port 0 destination register
- alu_data  in  DATA_W  port 0 write data
- ld_valid  in  1  port 1 write request
- ld_ready  out  1  port 1 buffer can accept
- ld_addr  in  ADDR_W  port 1 destination register
- ld_data  in  DATA_W  port 1 write data
- WriteAddress  out  ADDR_W  to register file, registered
- WriteData  out  DATA_W  to register file, registered
- ReadWriteEn  out  1  to register file write enable, registered
- pending_mask  out  2**ADDR_W  bit k set while any write to register k is buffered or on the output stage
- idle  out  1  both buffers empty and ReadWriteEn low

## Operation
- Per port: 2-entry FIFO (addr, data).
- Accept on valid && ready at the clock edge.
- ready = !full, combinational from FIFO count only; never depends on valid.
- Address 0 writes: handshake completes normally, but the entry is discarded. Never enqueued, never written, never in pending_mask.
- Arbitration each cycle over non-empty FIFO heads:
  - One non-empty: grant it.
  - Both non-empty: grant the port opposite last_grant.
  - On every grant, last_grant := granted port.
  - After reset, last_grant = 1, so port 0 wins the first contention.
- Granted head pops at the edge. The same edge loads the output stage: WriteAddress/WriteData := head, ReadWriteEn := 1.
- No grant: ReadWriteEn := 0; WriteAddress/WriteData hold their last values.
- Simultaneous push and pop on one FIFO in the same cycle:
  - Both take effect; count is unchanged.
  - A full FIFO shows ready=0, so it cannot push that cycle even if popping.
- pending_mask: combinational OR of one-hot(addr) over all valid FIFO entries, plus one-hot(WriteAddress) when ReadWriteEn = 1.
- Same address may appear in both ports. Ordering between ports is arbitration order; within a port, order is FIFO.
- Reset (async assert, any time, including mid-drain):
  - FIFOs emptied and last_grant = 1.
  - ReadWriteEn, WriteAddress, WriteData, pending_mask all 0.
  - alu_ready = ld_ready = 0 while rst_n low, 1 from the first cycle after release.
  - idle = 1 from the first cycle after release.
  - Buffered writes are lost; no partial write is issued.

## Timing
- Accept at edge N.
- Earliest grant in cycle N+1 (edge N+1 loads the output stage).
- Register file writes at edge N+2. Minimum latency is 2 cycles from handshake to architectural write.
- Throughput: one write per cycle total. A single port streaming alone sustains 1/cycle with ready held high.
- Both ports streaming: each gets 1/2 cycle; its FIFO fills and ready toggles.
- pending_mask bit sets in the cycle after accept. It clears in the cycle after the register-file write edge, unless another entry targets the same address.
- A read of register k while pending_mask[k] = 0 returns the committed value.

## Test plan
- Reset release:
  - alu_ready = ld_ready = 1, ReadWriteEn = 0, pending_mask = 0, idle = 1.
  - Assert rst_n low mid-cycle: outputs clear without a clock edge.
- Single write:
  - alu_valid with addr 2, data 0x0000_000D at edge 0.
  - Edge 1: ReadWriteEn=1, WriteAddress=2, WriteData=0xD.
  - pending_mask bit 2 high for cycles 1-2, low in cycle 3.
- Contention:
  - Both ports push every cycle: alu to r5 data 1,2,3…; ld to r6 data 100,101….
  - Output alternates alu, ld, alu, ld… starting with alu.
  - Each ready drops to 0 once its FIFO holds 2.
  - No entry lost or duplicated.
- Address 0:
  - ld_valid with addr 0, data 0xFFFF_FFFF.
  - ld_ready stays 1, ReadWriteEn never asserts, pending_mask stays 0.
- Same-address ordering:
  - alu writes r3=28, next cycle ld writes r3=7.
  - Writes issue in that order, final register value 7.
  - pending_mask[3] stays high until the second write is committed.
- Reset mid-operation:
  - Fill both FIFOs (4 entries), assert rst_n low for 1 cycle.
  - No further ReadWriteEn pulses, idle = 1 after release.
  - Next contention grants port 0 first.
